dma_mc_ctrl: RTL and testbench
==============================

Name: dma_mc_ctrl

Overview:
Multi-channel DMA controller that sits between the CPU's DMA command port and the shared memory bus. It generalises the single-channel begin/end/BR/BG handshake to NUM_CH channels with per-channel descriptors. Arbitration across channels is round-robin. Each command selects burst mode or cycle-stealing mode. The block drives block-wide memory writes while the CPU holds off through the BR/BG bus handshake.

Parameters:
NUM_CH, 2, number of independent DMA channels (1..8)
WORD_SIZE, 16, address width in bits
BLK_WORDS, 4, words per memory block; address step per block
MEM_LAT, 4, cycles per block write on the memory bus
LEN_W, 8, width of the block-count field in a command

Ports:
Clk  in  1  clock
Reset_N  in  1  reset
cmd_valid  in  1  CPU presents a command
cmd_ready  out  1  command accepted this cycle when cmd_valid&cmd_ready
cmd_ch  in  clog2(NUM_CH) (min 1)  target channel
cmd_addr  in  WORD_SIZE  start memory address
cmd_len  in  LEN_W  number of blocks
cmd_mode  in  1  0 = burst (hold bus for whole transfer), 1 = cycle-steal (release after each block)
BR  out  1  bus request to CPU
BG  in  1  bus grant from CPU
mem_write  out  1  memory write strobe, high for the whole block write
mem_address  out  WORD_SIZE  block address being written
dev_sel  out  clog2(NUM_CH) (min 1)  channel whose device drives data
blk_phase  out  clog2(MEM_LAT) (min 1)  cycle index inside the current block write
busy  out  NUM_CH  per-channel descriptor pending or active
done_irq  out  NUM_CH  one-cycle completion pulse per channel

Behaviour:
- Reset: Reset_N, synchronous, active-low; clock Clk. While low, all outputs are 0 and all descriptors are cleared. The round-robin pointer resets to channel 0 and the FSM goes to IDLE. Reset mid-transfer aborts with no done_irq.
- cmd_ready = !busy[cmd_ch] and not in reset; combinational.
- On accept with cmd_len>0, the channel latches addr, len and mode, and busy[ch] rises the next cycle.
- On accept with cmd_len=0, busy stays 0 and done_irq[ch] pulses the next cycle. No bus request is made.
- Descriptor: cur_addr, remaining (LEN_W bits), mode.
- FSM states: IDLE, REQ, XFER, REL.
- IDLE: if any busy, pick the first busy channel at or after rr_ptr, with wrap-around. Store it in sel and go to REQ the next cycle. BR=0.
- REQ: BR=1. Wait for BG=1, then XFER with phase=0.
- XFER: BR=1, mem_write=1, mem_address=cur_addr[sel], dev_sel=sel, blk_phase=phase. Phase increments each cycle.
- XFER, at phase=MEM_LAT-1, the block is complete: cur_addr += BLK_WORDS (mod 2^WORD_SIZE wrap) and remaining -= 1.
  - If remaining becomes 0: busy[sel] clears, done_irq[sel] pulses next cycle, rr_ptr = sel+1 (mod NUM_CH), go to REL.
  - Else if mode=1 (steal): rr_ptr = sel+1, go to REL.
  - Else (burst): stay in XFER with phase=0. No idle cycle between blocks.
- REL: BR=0. Wait for BG=0, then IDLE. The bus must be seen released before any re-request, so there is at least one CPU-owned cycle between steal blocks.
- BG falling during XFER: abort the partial block. mem_write drops the same cycle (combinationally gated by BG). cur_addr and remaining are unchanged, and the FSM goes to REQ, so the block is redone in full.
- BG=1 while in IDLE or REQ before BR rises is ignored. Only BG sampled in REQ grants.
- A new command to a non-busy channel is accepted in any state. It does not preempt the active channel.
- Simultaneous accept and completion on different channels: both take effect.
- Command to the channel completing this cycle: rejected, because busy is still 1 that cycle.
- Latency: accept to BR=1 is 2 cycles when IDLE. BG=1 to first mem_write is 1 cycle.
- Block of burst len N with BG held: N*MEM_LAT consecutive mem_write cycles.

Test Plan:
- Burst single channel: cmd ch0 addr=0x0100 len=3 mode=0, BG follows BR with 1-cycle delay -> 12 consecutive mem_write cycles, addresses 0x0100/0x0104/0x0108 for 4 cycles each, done_irq[0] one pulse, BR low afterwards.
- Steal mode: ch1 addr=0x0200 len=2 mode=1 -> two 4-cycle write groups, BR drops between them, second request only after BG=0 observed, done_irq[1] pulse after second.
- Round-robin: ch0 len=2 steal and ch1 len=2 steal queued together -> block order ch0,ch1,ch0,ch1, addresses incremented per channel independently.
- Grant revoked: burst len=2, drop BG at phase 2 of block 0 -> mem_write falls immediately, BR re-asserts, block 0 rewritten from phase 0 at same address, total 8 completed write cycles.
- Edge commands: len=0 on ch0 -> done_irq[0] next cycle, BR never rises. Command to busy ch0 -> cmd_ready=0. addr=0xFFFC len=2 -> second block at 0x0000.
- Reset mid-XFER: assert Reset_N=0 at phase 1 -> next cycle BR=0, mem_write=0, busy=0, no done_irq. Fresh command after release runs normally.

Source files
------------

// File: rtl/dma_mc_if.sv
// Command/bus interface of the multi-channel DMA controller.
// master = CPU / command side, slave = DMA controller.
interface dma_mc_if #(
  parameter int NUM_CH    = 2,
  parameter int WORD_SIZE = 16,
  parameter int MEM_LAT   = 4,
  parameter int LEN_W     = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PH_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [CH_W-1:0]      cmd_ch;
  logic [WORD_SIZE-1:0] cmd_addr;
  logic [LEN_W-1:0]     cmd_len;
  logic                 cmd_mode;
  logic                 BR;
  logic                 BG;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_address;
  logic [CH_W-1:0]      dev_sel;
  logic [PH_W-1:0]      blk_phase;
  logic [NUM_CH-1:0]    busy;
  logic [NUM_CH-1:0]    done_irq;

  modport master (
    output cmd_valid, cmd_ch, cmd_addr, cmd_len, cmd_mode, BG,
    input  cmd_ready, BR, mem_write, mem_address, dev_sel, blk_phase, busy, done_irq
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_addr, cmd_len, cmd_mode, BG,
    output cmd_ready, BR, mem_write, mem_address, dev_sel, blk_phase, busy, done_irq
  );
endinterface

// File: rtl/dma_mc_ctrl.sv
// Multi-channel DMA controller: per-channel block descriptors, round-robin
// channel selection, BR/BG bus handshake, burst or cycle-steal block writes.
module dma_mc_ctrl #(
  parameter int NUM_CH    = 2,
  parameter int WORD_SIZE = 16,
  parameter int BLK_WORDS = 4,
  parameter int MEM_LAT   = 4,
  parameter int LEN_W     = 8
) (
  input logic     Clk,
  input logic     Reset_N,
  dma_mc_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PH_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_REL} state_t;

  // Per-channel descriptors
  logic [WORD_SIZE-1:0] r_cur_addr  [NUM_CH];
  logic [LEN_W-1:0]     r_remaining [NUM_CH];
  logic [NUM_CH-1:0]    r_mode;
  logic [NUM_CH-1:0]    r_busy;
  logic [NUM_CH-1:0]    r_done_irq;

  // Bus-side FSM and its registered outputs
  state_t               r_state;
  logic [CH_W-1:0]      r_sel;
  logic [CH_W-1:0]      r_rr_ptr;
  logic [PH_W-1:0]      r_phase;
  logic                 r_br;
  logic                 r_xfer;
  logic [WORD_SIZE-1:0] r_mem_address;
  logic [CH_W-1:0]      r_dev_sel;

  logic                 w_ch_ok;
  logic                 w_cmd_ready;
  logic                 w_accept;
  logic                 w_any_busy;
  logic [CH_W-1:0]      w_pick;
  logic [CH_W-1:0]      w_sel_next;
  logic                 w_blk_end;
  logic                 w_blk_done;
  logic                 w_last_blk;
  logic [WORD_SIZE-1:0] w_next_addr;

  generate
    if ((1 << CH_W) == NUM_CH) begin : g_ch_full
      assign w_ch_ok = 1'b1;
    end else begin : g_ch_part
      assign w_ch_ok = (int'(bus.cmd_ch) < NUM_CH);
    end
  endgenerate

  assign w_cmd_ready = Reset_N & w_ch_ok & ~r_busy[bus.cmd_ch];
  assign w_accept    = bus.cmd_valid & w_cmd_ready;

  assign w_sel_next  = (r_sel == CH_W'(NUM_CH - 1)) ? '0 : r_sel + 1'b1;
  assign w_blk_end   = (r_phase == PH_W'(MEM_LAT - 1));
  assign w_blk_done  = (r_state == S_XFER) & bus.BG & w_blk_end;
  assign w_last_blk  = (r_remaining[r_sel] == LEN_W'(1));
  assign w_next_addr = r_cur_addr[r_sel] + WORD_SIZE'(BLK_WORDS);

  // Round-robin pick: scan downward so the smallest offset from r_rr_ptr wins.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch; a path
    // that leaves one unassigned would infer a latch.
    w_pick     = '0;
    w_any_busy = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      int j;
      j = int'(r_rr_ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (r_busy[CH_W'(j)]) begin
        w_pick     = CH_W'(j);
        w_any_busy = 1'b1;
      end
    end
  end

  // A channel being accepted is never the active one (it would still be busy),
  // so completion and accept updates never target the same entry.
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      // NOTE: descriptors are a handful of flops, not a RAM, so they take the
      // reset and read back as cleared.
      for (int i = 0; i < NUM_CH; i++) begin
        r_cur_addr[i]  <= '0;
        r_remaining[i] <= '0;
      end
      r_mode     <= '0;
      r_busy     <= '0;
      r_done_irq <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere in clocked logic, so the
      // default below is overridden per bit without any ordering hazard.
      r_done_irq <= '0;
      if (w_blk_done) begin
        r_cur_addr[r_sel]  <= w_next_addr;
        r_remaining[r_sel] <= r_remaining[r_sel] - 1'b1;
        if (w_last_blk) begin
          r_busy[r_sel]     <= 1'b0;
          r_done_irq[r_sel] <= 1'b1;
        end
      end
      if (w_accept) begin
        if (bus.cmd_len == '0) begin
          r_done_irq[bus.cmd_ch] <= 1'b1;
        end else begin
          r_busy[bus.cmd_ch]      <= 1'b1;
          r_cur_addr[bus.cmd_ch]  <= bus.cmd_addr;
          r_remaining[bus.cmd_ch] <= bus.cmd_len;
          r_mode[bus.cmd_ch]      <= bus.cmd_mode;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      r_state       <= S_IDLE;
      r_sel         <= '0;
      r_rr_ptr      <= '0;
      r_phase       <= '0;
      r_br          <= 1'b0;
      r_xfer        <= 1'b0;
      r_mem_address <= '0;
      r_dev_sel     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_busy) begin
            r_sel   <= w_pick;
            r_br    <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.BG) begin
            r_phase       <= '0;
            r_xfer        <= 1'b1;
            r_mem_address <= r_cur_addr[r_sel];
            r_dev_sel     <= r_sel;
            r_state       <= S_XFER;
          end
        end
        S_XFER: begin
          if (!bus.BG) begin
            // Grant lost mid-block: descriptor untouched, block redone in full.
            r_phase       <= '0;
            r_xfer        <= 1'b0;
            r_mem_address <= '0;
            r_dev_sel     <= '0;
            r_state       <= S_REQ;
          end else if (w_blk_end) begin
            if (w_last_blk || r_mode[r_sel]) begin
              r_rr_ptr      <= w_sel_next;
              r_br          <= 1'b0;
              r_phase       <= '0;
              r_xfer        <= 1'b0;
              r_mem_address <= '0;
              r_dev_sel     <= '0;
              r_state       <= S_REL;
            end else begin
              r_phase       <= '0;
              r_mem_address <= w_next_addr;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_REL: begin
          if (!bus.BG) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write strobe is gated by the live grant so a revoked bus is released at once.
  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.BR          = r_br;
  assign bus.mem_write   = r_xfer & bus.BG;
  assign bus.mem_address = r_mem_address;
  assign bus.dev_sel     = r_dev_sel;
  assign bus.blk_phase   = r_phase;
  assign bus.busy        = r_busy;
  assign bus.done_irq    = r_done_irq;

endmodule

// File: tb/tb_dma_mc_ctrl.sv
// Directed bench for dma_mc_ctrl: a simple CPU model answers BR with BG one
// cycle later (optionally lingering on release); every write cycle is logged.
module tb_dma_mc_ctrl;
  localparam int NUM_CH    = 2;
  localparam int WORD_SIZE = 16;
  localparam int BLK_WORDS = 4;
  localparam int MEM_LAT   = 4;
  localparam int LEN_W     = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dma_mc_if #(.NUM_CH(NUM_CH), .WORD_SIZE(WORD_SIZE), .MEM_LAT(MEM_LAT), .LEN_W(LEN_W)) bif ();

  dma_mc_ctrl #(
    .NUM_CH(NUM_CH), .WORD_SIZE(WORD_SIZE), .BLK_WORDS(BLK_WORDS),
    .MEM_LAT(MEM_LAT), .LEN_W(LEN_W)
  ) dut (
    .Clk    (clk),
    .Reset_N(reset_n),
    .bus    (bif.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int br_cnt, wr_n, rel_delay, hold;
  bit bg_follow;

  logic        s_br, s_mw, s_ready, s_dev;
  logic [15:0] s_addr;
  logic [1:0]  s_phase, s_busy, s_done;

  logic [15:0] wr_addr [64];
  logic        wr_dev  [64];
  logic [1:0]  wr_ph   [64];
  int          wr_cyc  [64];
  int          done_cnt [2];
  int          done_cyc [2];

  task automatic clear_log();
    wr_n   = 0;
    br_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0;
      done_cyc[i] = -1;
    end
    for (int i = 0; i < 64; i++) begin
      wr_addr[i] = 'x;
      wr_dev[i]  = 'x;
      wr_ph[i]   = 'x;
      wr_cyc[i]  = -1;
    end
  endtask

  // One clock cycle: sample at negedge, then (after posedge) the CPU model updates BG.
  task automatic step();
    @(negedge clk);
    s_br    = bif.BR;
    s_mw    = bif.mem_write;
    s_ready = bif.cmd_ready;
    s_addr  = bif.mem_address;
    s_dev   = bif.dev_sel;
    s_phase = bif.blk_phase;
    s_busy  = bif.busy;
    s_done  = bif.done_irq;
    if (s_br) br_cnt++;
    if (s_mw && wr_n < 64) begin
      wr_addr[wr_n] = s_addr;
      wr_dev[wr_n]  = s_dev;
      wr_ph[wr_n]   = s_phase;
      wr_cyc[wr_n]  = cyc;
      wr_n++;
    end
    for (int i = 0; i < 2; i++) begin
      if (s_done[i]) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
      end
    end
    @(posedge clk);
    #1;
    if (bg_follow) begin
      if (s_br) begin
        bif.BG = 1'b1;
        hold   = rel_delay;
      end else if (hold > 0) begin
        bif.BG = 1'b1;
        hold--;
      end else begin
        bif.BG = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic issue(input logic ch, input logic [15:0] addr, input logic [7:0] len,
                       input logic mode, output int acc);
    bif.cmd_ch    = ch;
    bif.cmd_addr  = addr;
    bif.cmd_len   = len;
    bif.cmd_mode  = mode;
    bif.cmd_valid = 1'b1;
    acc = cyc;
    step();
    bif.cmd_valid = 1'b0;
  endtask

  task automatic run_until(input logic [1:0] mask, input int budget);
    for (int k = 0; k < budget; k++) begin
      if ((!mask[0] || done_cnt[0] != 0) && (!mask[1] || done_cnt[1] != 0)) break;
      step();
    end
    repeat (6) step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    n_cmp++; if (s_br !== 1'b0) begin n_err++; $display("FAIL reset_br: got %0h want 0", s_br); end
    n_cmp++; if (s_mw !== 1'b0) begin n_err++; $display("FAIL reset_mem_write: got %0h want 0", s_mw); end
    n_cmp++; if (s_busy !== 2'b00) begin n_err++; $display("FAIL reset_busy: got %0h want 0", s_busy); end
    n_cmp++; if (s_done !== 2'b00) begin n_err++; $display("FAIL reset_done: got %0h want 0", s_done); end
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %0h want 0", s_ready); end
    reset_n = 1'b1;
    step();
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset: got %0h want 1", s_ready); end
  endtask

  task automatic test_burst();
    int acc;
    logic [15:0] ea;
    clear_log();
    rel_delay = 0;
    issue(1'b0, 16'h0100, 8'd3, 1'b0, acc);
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL burst_accept: got %0h want 1", s_ready); end
    step();
    n_cmp++; if (s_busy !== 2'b01) begin n_err++; $display("FAIL burst_busy: got %0h want 1", s_busy); end
    n_cmp++; if (s_br !== 1'b0) begin n_err++; $display("FAIL burst_br_early: got %0h want 0", s_br); end
    step();
    n_cmp++; if (s_br !== 1'b1) begin n_err++; $display("FAIL burst_br_latency: got %0h want 1", s_br); end
    run_until(2'b01, 40);
    n_cmp++; if (wr_n !== 12) begin n_err++; $display("FAIL burst_write_count: got %0d want 12", wr_n); end
    n_cmp++; if (wr_cyc[0] !== acc + 4) begin n_err++; $display("FAIL burst_first_write: got %0d want %0d", wr_cyc[0], acc + 4); end
    n_cmp++; if (wr_cyc[11] !== acc + 15) begin n_err++; $display("FAIL burst_last_write: got %0d want %0d", wr_cyc[11], acc + 15); end
    for (int i = 0; i < 12; i++) begin
      ea = 16'h0100 + 16'(4 * (i / 4));
      n_cmp++; if (wr_addr[i] !== ea) begin n_err++; $display("FAIL burst_addr[%0d]: got %0h want %0h", i, wr_addr[i], ea); end
      n_cmp++; if (wr_ph[i] !== 2'(i % 4)) begin n_err++; $display("FAIL burst_phase[%0d]: got %0d want %0d", i, wr_ph[i], i % 4); end
    end
    n_cmp++; if (done_cnt[0] !== 1) begin n_err++; $display("FAIL burst_done_count: got %0d want 1", done_cnt[0]); end
    n_cmp++; if (done_cyc[0] !== acc + 16) begin n_err++; $display("FAIL burst_done_cycle: got %0d want %0d", done_cyc[0], acc + 16); end
    n_cmp++; if (br_cnt !== 14) begin n_err++; $display("FAIL burst_br_cycles: got %0d want 14", br_cnt); end
    n_cmp++; if (s_br !== 1'b0) begin n_err++; $display("FAIL burst_br_after: got %0h want 0", s_br); end
    n_cmp++; if (s_busy !== 2'b00) begin n_err++; $display("FAIL burst_busy_after: got %0h want 0", s_busy); end
  endtask

  // CPU keeps BG for 3 extra cycles after BR drops; re-request must wait for BG=0.
  task automatic test_steal();
    int acc;
    clear_log();
    rel_delay = 3;
    issue(1'b1, 16'h0200, 8'd2, 1'b1, acc);
    run_until(2'b10, 60);
    rel_delay = 0;
    n_cmp++; if (wr_n !== 8) begin n_err++; $display("FAIL steal_write_count: got %0d want 8", wr_n); end
    n_cmp++; if (wr_addr[0] !== 16'h0200) begin n_err++; $display("FAIL steal_addr0: got %0h want 200", wr_addr[0]); end
    n_cmp++; if (wr_addr[4] !== 16'h0204) begin n_err++; $display("FAIL steal_addr1: got %0h want 204", wr_addr[4]); end
    n_cmp++; if (wr_dev[0] !== 1'b1 || wr_dev[7] !== 1'b1) begin n_err++; $display("FAIL steal_dev_sel: got %0h/%0h want 1/1", wr_dev[0], wr_dev[7]); end
    n_cmp++; if (wr_cyc[0] !== acc + 4) begin n_err++; $display("FAIL steal_first_write: got %0d want %0d", wr_cyc[0], acc + 4); end
    n_cmp++; if (wr_cyc[3] !== acc + 7) begin n_err++; $display("FAIL steal_group_len: got %0d want %0d", wr_cyc[3], acc + 7); end
    n_cmp++; if (wr_cyc[4] - wr_cyc[3] !== 9) begin n_err++; $display("FAIL steal_gap: got %0d want 9", wr_cyc[4] - wr_cyc[3]); end
    n_cmp++; if (br_cnt !== 12) begin n_err++; $display("FAIL steal_br_cycles: got %0d want 12", br_cnt); end
    n_cmp++; if (done_cnt[1] !== 1) begin n_err++; $display("FAIL steal_done_count: got %0d want 1", done_cnt[1]); end
    n_cmp++; if (done_cyc[1] !== acc + 20) begin n_err++; $display("FAIL steal_done_cycle: got %0d want %0d", done_cyc[1], acc + 20); end
  endtask

  task automatic test_round_robin();
    int a0, a1;
    logic [15:0] exp_addr [4];
    logic        exp_dev  [4];
    exp_addr = '{16'h0300, 16'h0400, 16'h0304, 16'h0404};
    exp_dev  = '{1'b0, 1'b1, 1'b0, 1'b1};
    clear_log();
    issue(1'b0, 16'h0300, 8'd2, 1'b1, a0);
    issue(1'b1, 16'h0400, 8'd2, 1'b1, a1);
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL rr_accept_ch1: got %0h want 1", s_ready); end
    run_until(2'b11, 100);
    n_cmp++; if (wr_n !== 16) begin n_err++; $display("FAIL rr_write_count: got %0d want 16", wr_n); end
    for (int g = 0; g < 4; g++) begin
      n_cmp++; if (wr_dev[4*g] !== exp_dev[g]) begin n_err++; $display("FAIL rr_dev[%0d]: got %0h want %0h", g, wr_dev[4*g], exp_dev[g]); end
      n_cmp++; if (wr_addr[4*g] !== exp_addr[g]) begin n_err++; $display("FAIL rr_addr[%0d]: got %0h want %0h", g, wr_addr[4*g], exp_addr[g]); end
    end
    n_cmp++; if (done_cnt[0] !== 1 || done_cnt[1] !== 1) begin n_err++; $display("FAIL rr_done: got %0d/%0d want 1/1", done_cnt[0], done_cnt[1]); end
  endtask

  task automatic test_grant_revoke();
    int acc;
    clear_log();
    bg_follow = 1'b0;
    bif.BG    = 1'b0;
    issue(1'b0, 16'h0500, 8'd2, 1'b0, acc);
    step();
    step();
    n_cmp++; if (s_br !== 1'b1) begin n_err++; $display("FAIL revoke_br: got %0h want 1", s_br); end
    bif.BG = 1'b1;
    step();
    step();
    n_cmp++; if (s_mw !== 1'b1 || s_addr !== 16'h0500) begin n_err++; $display("FAIL revoke_first_write: got %0h@%0h want 1@500", s_mw, s_addr); end
    step();
    bif.BG = 1'b0;
    step();
    n_cmp++; if (s_mw !== 1'b0) begin n_err++; $display("FAIL revoke_write_drop: got %0h want 0", s_mw); end
    n_cmp++; if (s_phase !== 2'd2) begin n_err++; $display("FAIL revoke_phase: got %0d want 2", s_phase); end
    step();
    n_cmp++; if (s_br !== 1'b1 || s_mw !== 1'b0) begin n_err++; $display("FAIL revoke_rerequest: got br=%0h mw=%0h want br=1 mw=0", s_br, s_mw); end
    bif.BG    = 1'b1;
    bg_follow = 1'b1;
    hold      = 0;
    step();
    run_until(2'b01, 40);
    n_cmp++; if (wr_n !== 10) begin n_err++; $display("FAIL revoke_write_count: got %0d want 10", wr_n); end
    n_cmp++; if (wr_addr[2] !== 16'h0500 || wr_ph[2] !== 2'd0) begin n_err++; $display("FAIL revoke_redo: got %0h ph %0d want 500 ph 0", wr_addr[2], wr_ph[2]); end
    n_cmp++; if (wr_cyc[2] !== acc + 9) begin n_err++; $display("FAIL revoke_redo_cycle: got %0d want %0d", wr_cyc[2], acc + 9); end
    n_cmp++; if (wr_addr[9] !== 16'h0504 || wr_cyc[9] !== acc + 16) begin n_err++; $display("FAIL revoke_last: got %0h@%0d want 504@%0d", wr_addr[9], wr_cyc[9], acc + 16); end
    n_cmp++; if (done_cnt[0] !== 1) begin n_err++; $display("FAIL revoke_done: got %0d want 1", done_cnt[0]); end
  endtask

  task automatic test_edge_cmds();
    int acc;
    clear_log();
    issue(1'b0, 16'h1234, 8'd0, 1'b0, acc);
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL len0_accept: got %0h want 1", s_ready); end
    step();
    n_cmp++; if (s_done !== 2'b01) begin n_err++; $display("FAIL len0_done: got %0h want 1", s_done); end
    n_cmp++; if (s_busy !== 2'b00) begin n_err++; $display("FAIL len0_busy: got %0h want 0", s_busy); end
    repeat (4) step();
    n_cmp++; if (br_cnt !== 0) begin n_err++; $display("FAIL len0_no_br: got %0d want 0", br_cnt); end
    n_cmp++; if (done_cnt[0] !== 1) begin n_err++; $display("FAIL len0_done_count: got %0d want 1", done_cnt[0]); end

    clear_log();
    issue(1'b0, 16'hFFFC, 8'd2, 1'b0, acc);
    bif.cmd_ch    = 1'b0;
    bif.cmd_addr  = 16'h0700;
    bif.cmd_len   = 8'd1;
    bif.cmd_mode  = 1'b0;
    bif.cmd_valid = 1'b1;
    step();
    bif.cmd_valid = 1'b0;
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL busy_reject: got %0h want 0", s_ready); end
    run_until(2'b01, 40);
    n_cmp++; if (wr_n !== 8) begin n_err++; $display("FAIL wrap_write_count: got %0d want 8", wr_n); end
    n_cmp++; if (wr_addr[0] !== 16'hFFFC) begin n_err++; $display("FAIL wrap_addr0: got %0h want fffc", wr_addr[0]); end
    n_cmp++; if (wr_addr[4] !== 16'h0000) begin n_err++; $display("FAIL wrap_addr1: got %0h want 0", wr_addr[4]); end
    n_cmp++; if (done_cnt[0] !== 1) begin n_err++; $display("FAIL wrap_done: got %0d want 1", done_cnt[0]); end
  endtask

  task automatic test_reset_mid();
    int acc;
    bit found;
    clear_log();
    found = 1'b0;
    issue(1'b1, 16'h0800, 8'd3, 1'b0, acc);
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (s_mw && s_phase == 2'd0) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL rstmid_reach_xfer: got no write within 20 cycles want write"); end
    reset_n = 1'b0;
    step();
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_ready: got %0h want 0", s_ready); end
    clear_log();
    step();
    n_cmp++; if (s_br !== 1'b0 || s_mw !== 1'b0) begin n_err++; $display("FAIL rstmid_bus: got br=%0h mw=%0h want 0/0", s_br, s_mw); end
    n_cmp++; if (s_busy !== 2'b00) begin n_err++; $display("FAIL rstmid_busy: got %0h want 0", s_busy); end
    reset_n = 1'b1;
    step();
    step();
    n_cmp++; if (done_cnt[1] !== 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt[1]); end

    clear_log();
    issue(1'b0, 16'h0900, 8'd1, 1'b0, acc);
    run_until(2'b01, 40);
    n_cmp++; if (wr_n !== 4) begin n_err++; $display("FAIL rstmid_fresh_count: got %0d want 4", wr_n); end
    n_cmp++; if (wr_addr[0] !== 16'h0900 || wr_cyc[0] !== acc + 4) begin n_err++; $display("FAIL rstmid_fresh_first: got %0h@%0d want 900@%0d", wr_addr[0], wr_cyc[0], acc + 4); end
    n_cmp++; if (done_cnt[0] !== 1) begin n_err++; $display("FAIL rstmid_fresh_done: got %0d want 1", done_cnt[0]); end
  endtask

  initial begin
    reset_n       = 1'b0;
    bif.cmd_valid = 1'b0;
    bif.cmd_ch    = '0;
    bif.cmd_addr  = '0;
    bif.cmd_len   = '0;
    bif.cmd_mode  = 1'b0;
    bif.BG        = 1'b0;
    bg_follow     = 1'b1;
    rel_delay     = 0;
    hold          = 0;
    clear_log();
    @(posedge clk);
    #1;
    test_reset();
    test_burst();
    test_steal();
    test_round_robin();
    test_grant_revoke();
    test_edge_cmds();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
